if_fetch_queue: RTL and testbench

Next-generation instruction fetch stage for the 5-stage MIPS core. It replaces the fixed single-cycle SRAM fetch with a handshaked request/response instruction port, so multiple fetches can be in flight. An in-order fetch queue of parametrised depth buffers instructions. Responses belonging to requests issued before a branch redirect are cancelled. It sits between the branch bus from the ID stage and the fs_to_ds pipeline register.

---
 rtl/if_fetch_queue_pkg.sv | 25 ++
 rtl/if_fetch_ring.sv | 109 ++++++++++
 rtl/if_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
//   CPU_XLEN / CPU_INST_LEN   : address and instruction widths
//   CPU_BR_BUS_WD             : {br_taken, br_target}
//   CPU_ADEL_W                : 1 when IF_ADDR_EXC_EN is defined, else 0
//   CPU_FS_TO_DS_BUS_WD       : {[adel], pc, inst}
//   CPU_RESET_PC              : first fetch address after reset
// Optional feature macro: IF_ADDR_EXC_EN (address-error entries).
package if_fetch_queue_pkg;

    localparam int CPU_XLEN       = 32;
    localparam int CPU_INST_LEN   = 32;
    localparam int CPU_IBUF_DEPTH = 4;
    localparam int CPU_BR_BUS_WD  = 1 + CPU_XLEN;

`ifdef IF_ADDR_EXC_EN
    localparam int CPU_ADEL_W = 1;
`else
    localparam int CPU_ADEL_W = 0;
`endif

    localparam int CPU_FS_TO_DS_BUS_WD = CPU_ADEL_W + CPU_XLEN + CPU_INST_LEN;

    localparam logic [31:0] CPU_RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/if_fetch_ring.sv
// Circular buffer of fetch entries {pc, inst, filled}.
// Entries are allocated at the tail, filled in allocation order, and popped
// from the head. Unfilled entries are always the youngest ones, so the oldest
// unfilled slot is tail - unfilled_cnt.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop every entry (head moves to tail)
//   alloc, alloc_pc     : allocate tail entry
//   alloc_filled        : allocate already filled with inst=0
//   fill, fill_inst     : write oldest unfilled entry
//   pop                 : retire head entry
//   head_*              : head entry contents
//   alloc_cnt           : allocated entries (filled or not)
//   unfilled_cnt        : allocated entries still waiting for data
// Optional feature macro: IF_ADDR_EXC_EN (handled by the top level).
module if_fetch_ring
    import if_fetch_queue_pkg::*;
#(
    parameter int XLEN     = CPU_XLEN,
    parameter int INST_LEN = CPU_INST_LEN,
    parameter int DEPTH    = CPU_IBUF_DEPTH,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                alloc,
    input  logic                alloc_filled,
    input  logic [XLEN-1:0]     alloc_pc,
    input  logic                fill,
    input  logic [INST_LEN-1:0] fill_inst,
    input  logic                pop,
    output logic                head_filled,
    output logic [XLEN-1:0]     head_pc,
    output logic [INST_LEN-1:0] head_inst,
    output logic [CW-1:0]       alloc_cnt,
    output logic [CW-1:0]       unfilled_cnt
);

    logic [XLEN-1:0]     pc_q   [DEPTH];
    logic [INST_LEN-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]    filled_q;
    logic [DEPTH-1:0]    filled_d;
    logic [AW-1:0]       head_q;
    logic [AW-1:0]       tail_q;
    logic [AW-1:0]       fill_idx;
    logic [CW-1:0]       alloc_cnt_q;
    logic [CW-1:0]       unfilled_q;
    logic                fill_ok;

    // A stray response with nothing waiting is ignored.
    assign fill_ok  = fill && (unfilled_q != '0);
    assign fill_idx = tail_q - unfilled_q[AW-1:0];

    always_comb begin
        filled_d = filled_q;
        if (pop) begin
            filled_d[head_q] = 1'b0;
        end
        if (fill_ok) begin
            filled_d[fill_idx] = 1'b1;
        end
        if (alloc) begin
            filled_d[tail_q] = alloc_filled;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
            filled_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush) begin
            head_q      <= tail_q;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
            filled_q    <= '0;
        end else begin
            filled_q <= filled_d;
            if (alloc) begin
                pc_q[tail_q]   <= alloc_pc;
                inst_q[tail_q] <= '0;
                tail_q         <= tail_q + AW'(1);
            end
            if (fill_ok) begin
                inst_q[fill_idx] <= fill_inst;
            end
            if (pop) begin
                head_q <= head_q + AW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CW'(alloc) - CW'(pop);
            unfilled_q  <= unfilled_q + CW'(alloc && !alloc_filled) - CW'(fill_ok);
        end
    end

    assign head_filled  = filled_q[head_q];
    assign head_pc      = pc_q[head_q];
    assign head_inst    = inst_q[head_q];
    assign alloc_cnt    = alloc_cnt_q;
    assign unfilled_cnt = unfilled_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a handshaked instruction port and an in-order
// fetch queue. Responses for requests issued before a redirect are dropped
// by counting them in cancel_cnt.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   ds_allowin          : ID stage accepts the head instruction
//   br_bus              : {br_taken, br_target}, br_taken is a 1-cycle pulse
//   inst_req/inst_addr  : fetch request
//   inst_addr_ok        : request accepted
//   inst_data_ok/rdata  : in-order response
//   fs_to_ds_valid/bus  : head entry {[adel], pc, inst}
// Optional feature macro: IF_ADDR_EXC_EN -- misaligned pcs allocate an entry
// marked as an address error instead of issuing a memory request.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              XLEN       = CPU_XLEN,
    parameter int              INST_LEN   = CPU_INST_LEN,
    parameter int              IBUF_DEPTH = CPU_IBUF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(CPU_RESET_PC)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ds_allowin,
    input  logic [XLEN:0]                        br_bus,
    output logic                                 inst_req,
    output logic [XLEN-1:0]                      inst_addr,
    input  logic                                 inst_addr_ok,
    input  logic                                 inst_data_ok,
    input  logic [INST_LEN-1:0]                  inst_rdata,
    output logic                                 fs_to_ds_valid,
    output logic [CPU_ADEL_W+XLEN+INST_LEN-1:0]  fs_to_ds_bus
);

    localparam int QW = $clog2(IBUF_DEPTH) + 1;
    localparam int CW = $clog2(2 * IBUF_DEPTH) + 1;

    logic                br_taken;
    logic [XLEN-1:0]     br_target;
    logic [XLEN-1:0]     fetch_pc_q;
    logic [CW-1:0]       cancel_cnt_q;
    logic [CW-1:0]       cancel_cnt_d;
    logic [CW-1:0]       cancel_sum;
    logic [CW-1:0]       outstanding;
    logic [QW-1:0]       alloc_cnt;
    logic [QW-1:0]       unfilled_cnt;
    logic                has_space;
    logic                below_limit;
    logic                pc_misaligned;
    logic                issue;
    logic                exc_alloc;
    logic                fill;
    logic                discard;
    logic                pop;
    logic                head_filled;
    logic [XLEN-1:0]     head_pc;
    logic [INST_LEN-1:0] head_inst;

    assign br_taken  = br_bus[XLEN];
    assign br_target = br_bus[XLEN-1:0];

    assign has_space   = alloc_cnt < QW'(IBUF_DEPTH);
    // Dropped plus live requests in flight; capping at 2*IBUF_DEPTH keeps
    // cancel_cnt within its width under repeated redirects.
    assign outstanding = cancel_cnt_q + CW'(unfilled_cnt);
    assign below_limit = outstanding < CW'(2 * IBUF_DEPTH);

`ifdef IF_ADDR_EXC_EN
    assign pc_misaligned = (fetch_pc_q[1:0] != 2'b00);
    assign exc_alloc     = reset && has_space && pc_misaligned && !br_taken;
`else
    assign pc_misaligned = 1'b0;
    assign exc_alloc     = 1'b0;
`endif

    assign inst_req  = reset && has_space && below_limit && !pc_misaligned;
    assign inst_addr = fetch_pc_q;
    assign issue     = inst_req && inst_addr_ok;

    assign discard = inst_data_ok && (cancel_cnt_q != '0);
    assign fill    = inst_data_ok && (cancel_cnt_q == '0) && !br_taken;
    assign pop     = fs_to_ds_valid && ds_allowin;

    if_fetch_ring #(
        .XLEN     (XLEN),
        .INST_LEN (INST_LEN),
        .DEPTH    (IBUF_DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst_n        (reset),
        .flush        (br_taken),
        .alloc        ((issue || exc_alloc) && !br_taken),
        .alloc_filled (exc_alloc),
        .alloc_pc     (fetch_pc_q),
        .fill         (fill),
        .fill_inst    (inst_rdata),
        .pop          (pop),
        .head_filled  (head_filled),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    // On a redirect every unfilled entry plus a request accepted this cycle
    // becomes a dropped response; a response arriving this cycle retires one.
    always_comb begin
        cancel_sum   = cancel_cnt_q + CW'(unfilled_cnt) + CW'(issue);
        cancel_cnt_d = cancel_cnt_q;
        if (br_taken) begin
            if (inst_data_ok && (cancel_sum != '0)) begin
                cancel_sum = cancel_sum - CW'(1);
            end
            cancel_cnt_d = cancel_sum;
        end else if (discard) begin
            cancel_cnt_d = cancel_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q   <= RESET_PC;
            cancel_cnt_q <= '0;
        end else begin
            cancel_cnt_q <= cancel_cnt_d;
            if (br_taken) begin
                fetch_pc_q <= br_target;
            end else if (issue || exc_alloc) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end
        end
    end

    assign fs_to_ds_valid = head_filled && !br_taken;

`ifdef IF_ADDR_EXC_EN
    assign fs_to_ds_bus = {(head_pc[1:0] != 2'b00), head_pc, head_inst};
`else
    assign fs_to_ds_bus = {head_pc, head_inst};
`endif

    // A response with nothing outstanding is a memory-side protocol error.
    always @(posedge clk) begin
        if (reset && inst_data_ok && (cancel_cnt_q == '0)) begin
            assert (unfilled_cnt != '0);
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int XL    = CPU_XLEN;
    localparam int IL    = CPU_INST_LEN;
    localparam int D     = 4;
    localparam int BUS_W = CPU_FS_TO_DS_BUS_WD;
    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ds_allowin = 1'b0;
    logic [XL:0]   br_bus = '0;
    logic          inst_req;
    logic [XL-1:0] inst_addr;
    logic          inst_addr_ok = 1'b0;
    logic          inst_data_ok = 1'b0;
    logic [IL-1:0] inst_rdata = '0;
    logic          fs_to_ds_valid;
    logic [BUS_W-1:0] fs_to_ds_bus;

    if_fetch_queue #(.IBUF_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ready; logic live; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic filled; logic adel; } sb_t;
    typedef struct { logic exp_valid; logic [31:0] exp_pc; } vec_t;

    pend_t pend[$];
    sb_t   sb[$];
    logic [31:0] model_pc = RST_PC;
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    bit    mem_hold = 0, force_resp = 0, aok_en = 0, rand_aok = 0;
    int    mem_delay = 1;
    int    dut_issued = 0;
    int    pop_cnt = 0;
    logic [31:0] last_pop_pc = '0;
    logic  s_valid, s_req;
    logic [31:0] s_pc, s_addr;
    vec_t  tbl[6];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock cycle: drive memory handshake at negedge, compare against the
    // model, advance the model by what happens at the coming posedge.
    task automatic step(input bit br, input logic [31:0] tgt);
        pend_t p;
        sb_t   e;
        bit    resp, exp_req, exp_valid, misal;
        int    sz0;
        @(negedge clk);
        br_bus = {br, tgt};
        resp = (pend.size() > 0) && (mem_hold ? force_resp : (pend[0].ready <= cyc));
        inst_data_ok = resp;
        inst_rdata   = resp ? inst_of(pend[0].addr) : '0;
        inst_addr_ok = rand_aok ? ($urandom_range(0, 3) != 0) : aok_en;
        #1;
        sz0   = sb.size();
        misal = 1'b0;
`ifdef IF_ADDR_EXC_EN
        misal = (model_pc[1:0] != 2'b00);
`endif
        exp_req = reset && !misal && (sz0 < D) && (pend.size() < 2 * D);
        check("inst_req", inst_req, exp_req);
        exp_valid = (sz0 > 0) && sb[0].filled && !br;
        check("fs_to_ds_valid", fs_to_ds_valid, exp_valid);
        s_valid = fs_to_ds_valid;
        s_req   = inst_req;
        s_addr  = inst_addr;
        s_pc    = fs_to_ds_bus[XL+IL-1:IL];
        if (inst_req && inst_addr_ok) dut_issued++;
        if (exp_valid && ds_allowin) begin
            check("head_pc", s_pc, sb[0].pc);
            check("head_inst", fs_to_ds_bus[IL-1:0], sb[0].inst);
`ifdef IF_ADDR_EXC_EN
            check("head_adel", fs_to_ds_bus[BUS_W-1], sb[0].adel);
`endif
            void'(sb.pop_front());
            pop_cnt++;
            last_pop_pc = s_pc;
        end
        if (resp) begin
            p = pend.pop_front();
            if (p.live) begin
                for (int i = 0; i < sb.size(); i++) begin
                    if (!sb[i].filled) begin
                        sb[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (exp_req && inst_addr_ok) begin
            check("inst_addr", inst_addr, model_pc);
            p.addr  = inst_addr;
            p.ready = cyc + ((mem_delay == 0) ? $urandom_range(1, 4) : mem_delay);
            p.live  = !br;
            pend.push_back(p);
            if (!br) begin
                e = '{pc: model_pc, inst: inst_of(model_pc), filled: 1'b0, adel: 1'b0};
                sb.push_back(e);
            end
            model_pc = model_pc + 32'd4;
        end
`ifdef IF_ADDR_EXC_EN
        if (reset && misal && (sz0 < D) && !br) begin
            e = '{pc: model_pc, inst: 32'h0, filled: 1'b1, adel: 1'b1};
            sb.push_back(e);
            model_pc = model_pc + 32'd4;
        end
`endif
        if (br) begin
            sb.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
            model_pc = tgt;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        aok_en = 0; rand_aok = 0; mem_hold = 0; force_resp = 0; ds_allowin = 1;
        while ((sb.size() > 0 || pend.size() > 0) && n < budget) begin
            step(0, 0);
            n++;
        end
        check("drain_left", sb.size() + pend.size(), 0);
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        int p0 = pop_cnt;
        int n = 0;
        while (pop_cnt == p0 && n < 40) begin
            step(0, 0);
            n++;
        end
        check(name, (pop_cnt != p0) ? last_pop_pc : 32'hdead_beef, exp_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'hbfc00000};
        tbl[3] = '{1'b1, 32'hbfc00004};
        tbl[4] = '{1'b1, 32'hbfc00008};
        tbl[5] = '{1'b1, 32'hbfc0000c};

        // reset state
        repeat (2) step(0, 0);
        check("rst_bus", fs_to_ds_bus, '0);
        check("rst_req", s_req, 0);

        // zero-wait memory, back-to-back delivery
        mem_delay = 1; aok_en = 1; ds_allowin = 1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            check("tbl_valid", s_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check("tbl_pc", s_pc, tbl[i].exp_pc);
        end
        drain(40);

        // slow memory, stalled consumer: queue fills, then resumes
        mem_delay = 5; aok_en = 1; ds_allowin = 0; dut_issued = 0;
        repeat (10) step(0, 0);
        check("full_issued", dut_issued, D);
        check("full_req", s_req, 0);
        ds_allowin = 1; dut_issued = 0;
        repeat (6) step(0, 0);
        check("resume_issue", dut_issued != 0, 1);
        drain(60);

        // three requests outstanding then redirect
        mem_hold = 1; aok_en = 1; ds_allowin = 1;
        repeat (3) step(0, 0);
        aok_en = 0;
        step(1, 32'h80001000);
        mem_hold = 0; mem_delay = 2; aok_en = 1;
        wait_pop("br_first_pc", 32'h80001000);
        drain(60);

        // redirect together with addr_ok and data_ok, two unfilled entries
        mem_hold = 1; aok_en = 1; ds_allowin = 0;
        repeat (3) step(0, 0);
        aok_en = 0; force_resp = 1;
        step(0, 0);
        force_resp = 0;
        step(0, 0);
        check("head_ready", s_valid, 1);
        aok_en = 1; force_resp = 1;
        step(1, 32'h80002000);
        check("br_same_valid", s_valid, 0);
        force_resp = 0; mem_hold = 0; mem_delay = 1; ds_allowin = 1;
        wait_pop("br2_first_pc", 32'h80002000);
        drain(60);

        // back-to-back redirects: last target wins
        mem_delay = 3; aok_en = 1; ds_allowin = 1;
        repeat (3) step(0, 0);
        step(1, 32'h80004000);
        step(1, 32'h80005000);
        wait_pop("b2b_first_pc", 32'h80005000);
        drain(60);

        // asynchronous reset mid-stream
        mem_hold = 1; aok_en = 1; ds_allowin = 0;
        repeat (4) step(0, 0);
        aok_en = 0; force_resp = 1;
        step(0, 0);
        force_resp = 0;
        #2 reset = 1'b0;
        #1;
        check("midrst_req", inst_req, 0);
        check("midrst_valid", fs_to_ds_valid, 0);
        check("midrst_bus", fs_to_ds_bus, '0);
        sb.delete(); pend.delete(); model_pc = RST_PC; mem_hold = 0;
        repeat (2) step(0, 0);
        reset = 1'b1; mem_delay = 1; aok_en = 1; ds_allowin = 1;
        step(0, 0);
        check("rst_first_addr", s_addr, RST_PC);
        drain(40);

        // random traffic
        mem_delay = 0; rand_aok = 1;
        for (int i = 0; i < 1500; i++) begin
            ds_allowin = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) step(1, $urandom() & 32'hffff_fffc);
            else step(0, 0);
        end
        drain(100);

`ifdef IF_ADDR_EXC_EN
        aok_en = 1; ds_allowin = 0; mem_delay = 1;
        step(1, 32'h80000002);
        step(0, 0);
        check("exc_req", s_req, 0);
        step(0, 0);
        check("exc_valid", s_valid, 1);
        check("exc_bus", fs_to_ds_bus, {1'b1, 32'h80000002, 32'h0});
        step(1, 32'h80003000);
        drain(40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
